// File: rtl/mux_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arb_pkg
//  Brief    : Shared types, default sizes and helpers for the round-robin
//             select arbiter that drives the 4:1 mux select.
//  Revision : 1.0  initial release
// ============================================================================
package mux_arb_pkg;

    // Default build: four mux inputs, bursts of four accepted transfers.
    localparam int N_IN_DEF      = 4;
    localparam int BURST_LEN_DEF = 4;

    // IDLE: nothing granted, output invalid. GRANT: sel/grant hold a source.
    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // One-hot decode of a select index. The result is 32 bits wide so the
    // helper serves any N_IN up to 32; callers truncate to N_IN bits.
    function automatic logic [31:0] onehot(input logic [4:0] idx);
        return 32'd1 << idx;
    endfunction

endpackage : mux_arb_pkg
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_priority_pick
//  Brief    : Combinational round-robin picker. Returns the first requesting
//             index when scanning ptr, ptr+1, ... modulo N_IN.
//  Revision : 1.0  initial release
// ============================================================================
module rr_priority_pick #(
    parameter int N_IN  = 4,
    parameter int SEL_W = $clog2(N_IN)
) (
    input  logic [N_IN-1:0]  req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] idx,
    output logic             any_req
);

    logic [SEL_W-1:0] w_cand;

    // Scan from the farthest offset back to ptr so the nearest requester
    // (lowest offset from ptr) is the one left in idx. N_IN is a power of
    // two, so the SEL_W-bit add wraps N_IN-1 -> 0 for free.
    always_comb begin
        idx     = '0;
        w_cand  = '0;
        any_req = |req;
        for (int k = N_IN - 1; k >= 0; k--) begin
            w_cand = ptr + SEL_W'(k);
            if (req[w_cand]) begin
                idx = w_cand;
            end
        end
    end

endmodule : rr_priority_pick
`default_nettype wire

// File: rtl/mux_rr_sel_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux_rr_sel_arbiter
//  Brief    : Round-robin arbiter driving the 4:1 mux select index, with a
//             valid/ready handshake toward the mux consumer. A granted source
//             keeps the select for up to BURST_LEN accepted transfers.
//  Options  : MUX_ARB_STATS_EN adds per-source saturating transfer counters
//             on output grant_cnt (N_IN*CNT_W bits, source i at [i*CNT_W +:
//             CNT_W]).
//  Revision : 1.0  initial release
// ============================================================================
module mux_rr_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N_IN      = N_IN_DEF,
    parameter int SEL_W     = $clog2(N_IN),
    parameter int BURST_LEN = BURST_LEN_DEF
`ifdef MUX_ARB_STATS_EN
    ,
    parameter int CNT_W     = 16
`endif
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_IN-1:0]       req,
    input  logic                  out_ready,
    output logic [SEL_W-1:0]      sel,
    output logic [N_IN-1:0]       grant,
    output logic                  out_valid,
    output logic                  last
`ifdef MUX_ARB_STATS_EN
    ,
    output logic [N_IN*CNT_W-1:0] grant_cnt
`endif
);

    // Beat counter needs at least one bit even when BURST_LEN is 1.
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BEAT_W-1:0] C_LAST_BEAT = BEAT_W'(BURST_LEN - 1);

    arb_state_t        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [BEAT_W-1:0] beat_q, beat_d;
    logic [N_IN-1:0]   grant_q, grant_d;
    logic              out_valid_q, out_valid_d;

    logic              w_xfer;
    logic              w_release;
    logic [SEL_W-1:0]  w_pick_ptr;
    logic [SEL_W-1:0]  w_pick_idx;
    logic              w_any_req;

    // A transfer is a handshake on the registered valid. The grant ends on
    // the final beat of the burst, or early when the owner has withdrawn
    // its request on a beat that is accepted anyway.
    assign w_xfer    = out_valid_q & out_ready;
    assign w_release = w_xfer & ((beat_q == C_LAST_BEAT) | ~req[sel_q]);

    // While granted, the only time the pick is consumed is at release, and
    // then the scan must start just past the current owner (ptr is only
    // updated at that same edge, so it cannot be used directly).
    assign w_pick_ptr = (state_q == GRANT) ? (sel_q + SEL_W'(1)) : ptr_q;

    rr_priority_pick #(
        .N_IN  (N_IN),
        .SEL_W (SEL_W)
    ) u_pick (
        .req     (req),
        .ptr     (w_pick_ptr),
        .idx     (w_pick_idx),
        .any_req (w_any_req)
    );

    // State and datapath registers; reset dominates any in-flight transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ptr_q       <= '0;
            beat_q      <= '0;
            grant_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            beat_q      <= beat_d;
            grant_q     <= grant_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state: grant on any request from IDLE; in GRANT hold everything
    // until release, then hand over with no bubble or fall back to IDLE.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (w_any_req) begin
                    state_d = GRANT;
                    sel_d   = w_pick_idx;
                end
            end
            GRANT: begin
                if (w_xfer) begin
                    beat_d = beat_q + BEAT_W'(1);
                end
                if (w_release) begin
                    ptr_d  = sel_q + SEL_W'(1);
                    beat_d = '0;
                    if (w_any_req) begin
                        sel_d = w_pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Registered outputs follow the next state so they are valid the cycle
    // the state register takes its new value.
    always_comb begin
        out_valid_d = (state_d == GRANT);
        grant_d     = out_valid_d ? N_IN'(onehot(5'(sel_d))) : '0;
    end

    assign sel       = sel_q;
    assign grant     = grant_q;
    assign out_valid = out_valid_q;
    assign last      = w_release;

`ifdef MUX_ARB_STATS_EN
    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_stats
            logic [CNT_W-1:0] cnt_q;

            // Count accepted transfers owned by this source, saturating.
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q <= '0;
                end else if (w_xfer && (sel_q == SEL_W'(gi)) && (cnt_q != C_CNT_MAX)) begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end

            assign grant_cnt[gi*CNT_W +: CNT_W] = cnt_q;
        end
    endgenerate
`endif

endmodule : mux_rr_sel_arbiter
`default_nettype wire
